ifft_frame_scheduler: RTL and testbench

//  Sequences the 8-point IFFT datapath for the baseband modulator.
//  - Collects a serial stream of mapped QAM symbols (valid/ready) into an 8-sample frame.
//  - Holds the frame stable on the IFFT input buses for the core latency, then captures the results.
//  - Emits the time-domain samples serially, prefixed by a cyclic prefix of CP_LEN samples.

---
 rtl/ifft_sched_pkg.sv | 19 +
 rtl/ifft_cp_serializer.sv | 72 +++++++
 rtl/ifft_frame_scheduler.sv | 94 +++++++++
 tb/tb_ifft_frame_scheduler.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ifft_sched_pkg.sv
// Shared constants, state encoding and beat-to-sample mapping for the IFFT frame scheduler.
package ifft_sched_pkg;
  localparam int N_PTS = 8;

  // 2'd3 is unused and decodes to FILL in the scheduler
  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_WAIT = 2'd1,
    S_EMIT = 2'd2
  } sched_state_e;

  // Capture slot emitted on a given beat: the first cp_len beats replay the tail
  // (starting at N_PTS-cp_len), then the frame runs 0..7; mod-8 covers both.
  function automatic logic [2:0] beat_src(input int beat, input int cp_len);
    int t;
    t = beat + N_PTS - cp_len;
    return t[2:0];
  endfunction
endpackage

// File: rtl/ifft_cp_serializer.sv
// Captures the IFFT results on load and streams them out with the cyclic prefix first.
module ifft_cp_serializer
  import ifft_sched_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CP_LEN = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [N_PTS*DATA_W-1:0] cap_re_in,
  input  logic [N_PTS*DATA_W-1:0] cap_im_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_re,
  output logic [DATA_W-1:0]       out_im,
  output logic                    out_sop,
  output logic                    out_eop,
  output logic                    done
);
  localparam int BEATS = CP_LEN + N_PTS;
  localparam int BW    = $clog2(BEATS);
  localparam logic [BW-1:0] LAST   = BW'(BEATS - 1);
  localparam logic [BW-1:0] PENULT = BW'(BEATS - 2);
  localparam logic [2:0]    FIRST  = beat_src(0, CP_LEN);

  logic [N_PTS-1:0][DATA_W-1:0] cap_re, cap_im, src_re, src_im;
  logic [BW-1:0] beat;
  logic [2:0]    nidx;

  assign src_re = cap_re_in;
  assign src_im = cap_im_in;
  assign nidx   = beat_src(int'(beat) + 1, CP_LEN);
  assign done   = out_valid && out_ready && (beat == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_re    <= '0;
      cap_im    <= '0;
      beat      <= '0;
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
    end else if (load) begin
      // beat 0 is taken straight off the bus so it is valid the cycle after capture
      cap_re    <= src_re;
      cap_im    <= src_im;
      beat      <= '0;
      out_valid <= 1'b1;
      out_re    <= src_re[FIRST];
      out_im    <= src_im[FIRST];
      out_sop   <= 1'b1;
      out_eop   <= 1'b0;
    end else if (out_valid && out_ready) begin
      out_sop <= 1'b0;
      if (beat == LAST) begin
        beat      <= '0;
        out_valid <= 1'b0;
        out_re    <= '0;
        out_im    <= '0;
        out_eop   <= 1'b0;
      end else begin
        beat    <= beat + 1'b1;
        out_re  <= cap_re[nidx];
        out_im  <= cap_im[nidx];
        out_eop <= (beat == PENULT);
      end
    end
  end
endmodule

// File: rtl/ifft_frame_scheduler.sv
// Collects 8 serial symbols, holds them on the IFFT inputs for IFFT_LAT cycles,
// then hands the results to the CP serializer; one frame in flight at a time.
module ifft_frame_scheduler
  import ifft_sched_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int IFFT_LAT = 4,
  parameter int CP_LEN   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_re,
  input  logic [DATA_W-1:0]       in_im,
  output logic [N_PTS*DATA_W-1:0] ifft_in_re,
  output logic [N_PTS*DATA_W-1:0] ifft_in_im,
  input  logic [N_PTS*DATA_W-1:0] ifft_out_re,
  input  logic [N_PTS*DATA_W-1:0] ifft_out_im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_re,
  output logic [DATA_W-1:0]       out_im,
  output logic                    out_sop,
  output logic                    out_eop,
  output logic                    busy
);
  localparam int WCW = (IFFT_LAT > 0) ? $clog2(IFFT_LAT + 1) : 1;

  sched_state_e state;
  logic [2:0]   wr_idx;
  logic [WCW-1:0] wcnt;
  logic [N_PTS-1:0][DATA_W-1:0] frame_re, frame_im;
  logic in_wait, in_emit, load, done;

  assign in_wait    = (state == S_WAIT);
  assign in_emit    = (state == S_EMIT);
  assign busy       = in_wait || in_emit;
  assign in_ready   = !busy;
  assign load       = in_wait && (wcnt == '0);
  assign ifft_in_re = frame_re;
  assign ifft_in_im = frame_im;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FILL;
      wr_idx   <= '0;
      wcnt     <= '0;
      frame_re <= '0;
      frame_im <= '0;
    end else begin
      case (state)
        S_WAIT: begin
          if (wcnt == '0) state <= S_EMIT;
          else            wcnt  <= wcnt - 1'b1;
        end
        S_EMIT: begin
          if (done) state <= S_FILL;
        end
        default: begin
          if (in_valid) begin
            frame_re[wr_idx] <= in_re;
            frame_im[wr_idx] <= in_im;
            if (wr_idx == 3'd7) begin
              wr_idx <= '0;
              state  <= S_WAIT;
              wcnt   <= WCW'(IFFT_LAT);
            end else begin
              wr_idx <= wr_idx + 3'd1;
            end
          end
        end
      endcase
    end
  end

  ifft_cp_serializer #(
    .DATA_W(DATA_W),
    .CP_LEN(CP_LEN)
  ) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .cap_re_in(ifft_out_re),
    .cap_im_in(ifft_out_im),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_re   (out_re),
    .out_im   (out_im),
    .out_sop  (out_sop),
    .out_eop  (out_eop),
    .done     (done)
  );
endmodule

// File: tb/tb_ifft_frame_scheduler.sv
// Two schedulers (CP_LEN=2 and CP_LEN=0) on identity IFFT stubs, checked by a queue scoreboard.
module tb_ifft_frame_scheduler;
  localparam int DW  = 16;
  localparam int NP  = 8;
  localparam int LAT = 4;

  typedef struct {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          sop;
    logic          eop;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst, in_valid, in_ready, out_valid, out_ready, out_sop, out_eop, busy;
  logic [1:0][DW-1:0]    in_re, in_im, out_re, out_im;
  logic [1:0][NP*DW-1:0] fi_re, fi_im, fo_re, fo_im;

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int CP = (g == 0) ? 2 : 0;
    logic [NP*DW-1:0] dre [LAT];
    logic [NP*DW-1:0] dim [LAT];

    ifft_frame_scheduler #(.DATA_W(DW), .IFFT_LAT(LAT), .CP_LEN(CP)) dut (
      .clk(clk), .rst(rst[g]),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_re(in_re[g]), .in_im(in_im[g]),
      .ifft_in_re(fi_re[g]), .ifft_in_im(fi_im[g]),
      .ifft_out_re(fo_re[g]), .ifft_out_im(fo_im[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .out_re(out_re[g]), .out_im(out_im[g]),
      .out_sop(out_sop[g]), .out_eop(out_eop[g]), .busy(busy[g])
    );

    // identity IFFT: out_k = in_k, LAT cycles later
    always @(posedge clk) begin
      dre[0] <= fi_re[g];
      dim[0] <= fi_im[g];
      for (int i = 1; i < LAT; i++) begin
        dre[i] <= dre[i-1];
        dim[i] <= dim[i-1];
      end
    end
    assign fo_re[g] = dre[LAT-1];
    assign fo_im[g] = dim[LAT-1];
  end

  // Reference model and scoreboard state (owned by the monitor)
  beat_t         exp_q  [2][$];
  logic [DW-1:0] part_re[2][$];
  logic [DW-1:0] part_im[2][$];
  bit    mbusy[2];
  bit    lat_pend[2];
  bit    pstall[2];
  beat_t pval[2];
  int    acc_cyc[2];
  int    beats_seen[2];
  int    cyc, errors, checks, tmo_seen;

  // Stimulus-owned requests
  int         rdy_mode;
  logic [1:0] idle_req;
  int         tmo_cnt;

  task automatic chk(input bit ok, input string name, input string got, input string want);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %s, expected %s", name, cyc, got, want);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready[0] = 1'b1;
      1:       out_ready[0] = ~out_ready[0];
      default: out_ready[0] = 1'($urandom_range(0, 1));
    endcase
    out_ready[1] = 1'b1;
  end

  always @(negedge clk) begin
    cyc++;
    if (tmo_cnt != tmo_seen) begin
      chk(1'b0, "timeout", $sformatf("%0d expired waits", tmo_cnt - tmo_seen), "0");
      tmo_seen = tmo_cnt;
    end
    for (int g = 0; g < 2; g++) begin
      int cp;
      cp = (g == 0) ? 2 : 0;
      if (idle_req[g])
        chk(!out_valid[g] && out_re[g] == '0 && out_im[g] == '0 && !out_sop[g] && !out_eop[g]
            && in_ready[g] && !busy[g] && fi_re[g] == '0 && fi_im[g] == '0, "idle",
            $sformatf("lane%0d v=%b re=%h im=%h rdy=%b busy=%b", g, out_valid[g], out_re[g],
                      out_im[g], in_ready[g], busy[g]), "v=0 re=0 im=0 rdy=1 busy=0");
      if (rst[g]) begin
        exp_q[g].delete();
        part_re[g].delete();
        part_im[g].delete();
        mbusy[g] = 0; lat_pend[g] = 0; pstall[g] = 0; beats_seen[g] = 0;
        continue;
      end
      chk(in_ready[g] == !mbusy[g] && busy[g] == mbusy[g], "ready_busy",
          $sformatf("lane%0d rdy=%b busy=%b", g, in_ready[g], busy[g]),
          $sformatf("rdy=%b busy=%b", !mbusy[g], mbusy[g]));
      if (pstall[g])
        chk(out_valid[g] && out_re[g] == pval[g].re && out_im[g] == pval[g].im
            && out_sop[g] == pval[g].sop && out_eop[g] == pval[g].eop, "stall_hold",
            $sformatf("lane%0d v=%b re=%h im=%h", g, out_valid[g], out_re[g], out_im[g]),
            $sformatf("v=1 re=%h im=%h", pval[g].re, pval[g].im));
      if (out_valid[g] && lat_pend[g]) begin
        // accept seen on the negedge before its edge; rise is LAT+1 edges later
        chk(cyc - acc_cyc[g] == LAT + 2, "latency", $sformatf("%0d", cyc - acc_cyc[g]),
            $sformatf("%0d", LAT + 2));
        lat_pend[g] = 0;
      end
      if (out_valid[g] && out_ready[g]) begin
        if (exp_q[g].size() == 0) begin
          chk(1'b0, "unexpected_beat", $sformatf("lane%0d re=%h", g, out_re[g]), "no beat");
        end else begin
          beat_t e;
          e = exp_q[g].pop_front();
          chk(out_re[g] == e.re && out_im[g] == e.im && out_sop[g] == e.sop && out_eop[g] == e.eop,
              "beat", $sformatf("lane%0d re=%h im=%h sop=%b eop=%b", g, out_re[g], out_im[g],
                                out_sop[g], out_eop[g]),
              $sformatf("re=%h im=%h sop=%b eop=%b", e.re, e.im, e.sop, e.eop));
          beats_seen[g]++;
          if (e.eop) begin
            mbusy[g] = 0;
            beats_seen[g] = 0;
          end
        end
      end
      pstall[g]   = out_valid[g] && !out_ready[g];
      pval[g].re  = out_re[g];
      pval[g].im  = out_im[g];
      pval[g].sop = out_sop[g];
      pval[g].eop = out_eop[g];
      if (in_valid[g] && in_ready[g]) begin
        part_re[g].push_back(in_re[g]);
        part_im[g].push_back(in_im[g]);
        if (part_re[g].size() == NP) begin
          for (int c = 0; c < cp; c++)
            exp_q[g].push_back('{part_re[g][NP-cp+c], part_im[g][NP-cp+c], c == 0, 1'b0});
          for (int k = 0; k < NP; k++)
            exp_q[g].push_back('{part_re[g][k], part_im[g][k], cp == 0 && k == 0, k == NP-1});
          part_re[g].delete();
          part_im[g].delete();
          mbusy[g]    = 1;
          acc_cyc[g]  = cyc;
          lat_pend[g] = 1;
        end
      end
    end
  end

  task automatic send(input int g, input logic [DW-1:0] re, input logic [DW-1:0] im);
    int n;
    in_valid[g] = 1'b1;
    in_re[g] = re;
    in_im[g] = im;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready[g]) break;
      if (++n > 200) begin
        tmo_cnt++;
        break;
      end
    end
    @(posedge clk); #1;
    in_valid[g] = 1'b0;
  endtask

  task automatic drain(input int g);
    int n;
    n = 0;
    while ((exp_q[g].size() != 0 || out_valid[g] || mbusy[g]) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) tmo_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic idle_check(input logic [1:0] mask);
    idle_req = mask;
    @(negedge clk); #1;
    idle_req = 2'b00;
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    rst = 2'b11; in_valid = '0; in_re = '0; in_im = '0;
    rdy_mode = 0; idle_req = '0; tmo_cnt = 0;
    repeat (3) @(posedge clk);
    #1 rst = 2'b00;
    idle_check(2'b11);

    // CP_LEN=0 lane: one frame k=0..7, emitted while lane 0 runs its tests
    for (int k = 0; k < NP; k++) send(1, DW'(k), DW'(k + 'h100));

    // 1: counting frame, downstream always ready
    for (int k = 0; k < NP; k++) send(0, DW'(k + 1), DW'(-(k + 1)));
    drain(0);

    // 2: same frame with out_ready toggling
    rdy_mode = 1;
    for (int k = 0; k < NP; k++) send(0, DW'(k + 1), DW'(-(k + 1)));
    drain(0);

    // 3: in_valid held for 16 symbols across two frames
    rdy_mode = 0;
    for (int k = 0; k < 2*NP; k++) send(0, DW'('h40 + k), DW'('h80 + k));
    drain(0);

    // 4: reset after 5 inputs discards them
    for (int k = 0; k < 5; k++) send(0, DW'('h30 + k), DW'('h70 + k));
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    for (int k = 0; k < NP; k++) send(0, DW'('h10 + k), DW'('h50 + k));
    drain(0);

    // 5: reset while beat 4 is presented
    for (int k = 0; k < NP; k++) send(0, DW'('h60 + k), DW'('h90 + k));
    n = 0;
    while (beats_seen[0] != 4 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (n >= 200) tmo_cnt++;
    #1 rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    idle_check(2'b01);

    // random frames, random gaps, random backpressure
    rdy_mode = 2;
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < NP; k++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
        send(0, DW'($urandom), DW'($urandom));
      end
    end
    drain(0);
    drain(1);

    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
